// File: rtl/wrr_pop_scheduler.sv
// Weighted round-robin pop scheduler: drains a bank of first-word-fall-through FIFOs
// into one registered valid/ready output, granting each queue up to its weight per turn.
module wrr_pop_scheduler #(
   parameter int QUEUE_QUANTITY = 4,
   parameter int DATA_BITS      = 8,
   parameter int MAX_WEIGHT     = 64
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         enb,
   input  logic [QUEUE_QUANTITY*$clog2(MAX_WEIGHT)-1:0] pesos,
   input  logic [QUEUE_QUANTITY-1:0]                    buf_empty,
   input  logic [QUEUE_QUANTITY*DATA_BITS-1:0]          fifo_data,
   output logic [QUEUE_QUANTITY-1:0]                    pop,
   output logic [DATA_BITS-1:0]                         data_out,
   output logic [$clog2(QUEUE_QUANTITY)-1:0]            grant_id,
   output logic                                         valid_out,
   input  logic                                         ready_in
);

   localparam int W       = $clog2(MAX_WEIGHT);
   localparam int ID_BITS = $clog2(QUEUE_QUANTITY);

   typedef enum logic [1:0] {
      DEC_NONE,
      DEC_CONTINUE,
      DEC_NEW_TURN
   } decision_e;

   logic [ID_BITS-1:0]   r_cur;
   logic [W-1:0]         r_credit;
   logic [DATA_BITS-1:0] r_data_out;
   logic [ID_BITS-1:0]   r_grant_id;
   logic                 r_valid_out;

   logic [W-1:0]              w_weight   [QUEUE_QUANTITY];
   logic [DATA_BITS-1:0]      w_word     [QUEUE_QUANTITY];
   logic [QUEUE_QUANTITY-1:0] w_eligible;
   logic                      w_can_issue;
   logic                      w_found;
   logic [ID_BITS-1:0]        w_next_q;
   decision_e                 w_decision;
   logic [ID_BITS-1:0]        w_sel_q;

   always_comb begin
      for (int n = 0; n < QUEUE_QUANTITY; n++) begin
         w_weight[n]   = pesos[n*W +: W];
         w_word[n]     = fifo_data[n*DATA_BITS +: DATA_BITS];
         w_eligible[n] = !buf_empty[n] && (w_weight[n] != '0);
      end
   end

   assign w_can_issue = enb && !rst && (!r_valid_out || ready_in);

   // New-turn search starts just after cur and wraps around, so cur itself is tried last.
   always_comb begin
      // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
      w_found  = 1'b0;
      w_next_q = r_cur;
      for (int i = 1; i <= QUEUE_QUANTITY; i++) begin
         if (!w_found && w_eligible[ID_BITS'(r_cur + ID_BITS'(i))]) begin
            w_found  = 1'b1;
            w_next_q = ID_BITS'(r_cur + ID_BITS'(i));
         end
      end
   end

   always_comb begin
      w_decision = DEC_NONE;
      w_sel_q    = r_cur;
      if (w_can_issue) begin
         if ((r_credit != '0) && w_eligible[r_cur]) begin
            w_decision = DEC_CONTINUE;
            w_sel_q    = r_cur;
         end else if (w_found) begin
            w_decision = DEC_NEW_TURN;
            w_sel_q    = w_next_q;
         end
      end
   end

   always_comb begin
      pop = '0;
      if (w_decision != DEC_NONE) begin
         pop[w_sel_q] = 1'b1;
      end
   end

   // Weight is captured only when a turn starts; pesos changes mid-turn wait for the next turn.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_cur       <= ID_BITS'(QUEUE_QUANTITY - 1);
         r_credit    <= '0;
         r_data_out  <= '0;
         r_grant_id  <= '0;
         r_valid_out <= 1'b0;
      end else begin
         case (w_decision)
            DEC_CONTINUE: r_credit <= r_credit - W'(1);
            DEC_NEW_TURN: begin
               r_cur    <= w_next_q;
               r_credit <= w_weight[w_next_q] - W'(1);
            end
            default: ;
         endcase
         if (w_decision != DEC_NONE) begin
            r_data_out  <= w_word[w_sel_q];
            r_grant_id  <= w_sel_q;
            r_valid_out <= 1'b1;
         end else if (w_can_issue) begin
            r_valid_out <= 1'b0;
         end
      end
   end

   assign data_out  = r_data_out;
   assign grant_id  = r_grant_id;
   assign valid_out = r_valid_out;

endmodule

// File: tb/tb_wrr_pop_scheduler.sv
// Self-checking bench for wrr_pop_scheduler: the bench owns the FIFO bank and a
// queue-level reference model, and checks directed scenarios plus a random soak.
module tb_wrr_pop_scheduler;

   localparam int Q     = 4;
   localparam int DB    = 8;
   localparam int WB    = 6;
   localparam int DEPTH = 64;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            enb = 1'b0;
   logic            ready_in = 1'b0;
   logic [Q*WB-1:0] pesos = '0;
   logic [Q-1:0]    buf_empty = '1;
   logic [Q*DB-1:0] fifo_data = '0;
   logic [Q-1:0]    pop;
   logic [DB-1:0]   data_out;
   logic [1:0]      grant_id;
   logic            valid_out;

   always #5 clk = ~clk;

   wrr_pop_scheduler #(
      .QUEUE_QUANTITY(Q),
      .DATA_BITS     (DB),
      .MAX_WEIGHT    (64)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .enb      (enb),
      .pesos    (pesos),
      .buf_empty(buf_empty),
      .fifo_data(fifo_data),
      .pop      (pop),
      .data_out (data_out),
      .grant_id (grant_id),
      .valid_out(valid_out),
      .ready_in (ready_in)
   );

   int total = 0;
   int bad   = 0;

   int            wts  [Q];
   logic [DB-1:0] mem  [Q][DEPTH];
   int            head [Q];
   int            cnt  [Q];

   int            m_cur;
   int            m_credit;
   logic          m_valid;
   logic [DB-1:0] m_data;
   int            m_gid;

   int seen  [$];
   int exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void push(input int q, input logic [DB-1:0] d);
      mem[q][(head[q] + cnt[q]) % DEPTH] = d;
      cnt[q]++;
   endfunction

   function automatic void fill(input int q, input int n);
      for (int i = 0; i < n; i++) push(q, DB'($urandom));
   endfunction

   function automatic void clear_fifos();
      for (int q = 0; q < Q; q++) begin
         head[q] = 0;
         cnt[q]  = 0;
      end
   endfunction

   task automatic drive_inputs();
      for (int n = 0; n < Q; n++) begin
         buf_empty[n]         = (cnt[n] == 0);
         fifo_data[n*DB +: DB] = (cnt[n] != 0) ? mem[n][head[n]] : DB'($urandom);
         pesos[n*WB +: WB]     = WB'(wts[n]);
      end
   endtask

   function automatic void model_reset();
      m_cur    = Q - 1;
      m_credit = 0;
      m_valid  = 1'b0;
      m_data   = '0;
      m_gid    = 0;
   endfunction

   function automatic bit elig(input int q);
      return (cnt[q] > 0) && (wts[q] != 0);
   endfunction

   // Which queue the scheduler should pop this cycle (-1 = none); cont marks a continued turn.
   function automatic int model_pick(output bit cont);
      cont = 1'b0;
      if (!enb || rst || (m_valid && !ready_in)) return -1;
      if ((m_credit > 0) && elig(m_cur)) begin
         cont = 1'b1;
         return m_cur;
      end
      for (int k = 1; k <= Q; k++) begin
         if (elig((m_cur + k) % Q)) return (m_cur + k) % Q;
      end
      return -1;
   endfunction

   function automatic void model_update(input int p, input bit cont);
      bit can;
      if (rst) begin
         model_reset();
         return;
      end
      can = enb && (!m_valid || ready_in);
      if (p >= 0) begin
         if (cont) begin
            m_credit = m_credit - 1;
         end else begin
            m_cur    = p;
            m_credit = wts[p] - 1;
         end
         m_data  = mem[p][head[p]];
         head[p] = (head[p] + 1) % DEPTH;
         cnt[p]  = cnt[p] - 1;
         m_valid = 1'b1;
         m_gid   = p;
      end else if (can) begin
         m_valid = 1'b0;
      end
   endfunction

   task automatic tick(input string tag);
      int          p;
      bit          cont;
      logic [31:0] exp_pop;
      drive_inputs();
      @(negedge clk);
      p       = model_pick(cont);
      exp_pop = (p < 0) ? 32'd0 : (32'd1 << p);
      check({tag, ".pop"},       32'(pop),       exp_pop);
      check({tag, ".valid_out"}, 32'(valid_out), 32'(m_valid));
      check({tag, ".data_out"},  32'(data_out),  32'(m_data));
      check({tag, ".grant_id"},  32'(grant_id),  32'(m_gid));
      for (int i = 0; i < Q; i++) if (pop[i]) seen.push_back(i);
      @(posedge clk);
      model_update(p, cont);
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      tick(tag);
      rst = 1'b0;
      check({tag, ".valid_after"},    32'(valid_out), 32'd0);
      check({tag, ".data_after"},     32'(data_out),  32'd0);
      check({tag, ".grant_id_after"}, 32'(grant_id),  32'd0);
      seen.delete();
   endtask

   task automatic check_seq(input string tag);
      check({tag, ".len"}, 32'(seen.size()), 32'(exp_q.size()));
      for (int i = 0; i < seen.size() && i < exp_q.size(); i++) begin
         check($sformatf("%s[%0d]", tag, i), 32'(seen[i]), 32'(exp_q[i]));
      end
   endtask

   // Grant order for weights {q3..q0}={4,3,2,1}: 0,1,1,2,2,2,3,3,3,3 repeating.
   task automatic build_pattern(input int n);
      exp_q.delete();
      while (exp_q.size() < n) begin
         for (int q = 0; q < Q && exp_q.size() < n; q++) begin
            for (int r = 0; r <= q && exp_q.size() < n; r++) exp_q.push_back(q);
         end
      end
   endtask

   logic [DB-1:0] hold_data;
   logic [1:0]    hold_gid;

   initial begin
      enb      = 1'b1;
      ready_in = 1'b1;
      wts      = '{1, 1, 1, 1};
      clear_fifos();
      drive_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      model_reset();

      // Weighted order with every FIFO full.
      wts = '{1, 2, 3, 4};
      clear_fifos();
      for (int q = 0; q < Q; q++) fill(q, 30);
      do_reset("s1_rst");
      repeat (20) tick("s1");
      build_pattern(20);
      check_seq("s1_seq");

      // Empty FIFO1 is skipped.
      wts = '{2, 2, 2, 2};
      clear_fifos();
      fill(0, 10); fill(2, 10); fill(3, 10);
      do_reset("s2_rst");
      repeat (8) tick("s2");
      exp_q = '{0, 0, 2, 2, 3, 3, 0, 0};
      check_seq("s2_seq");

      // Weight-0 queue is never popped even with data.
      wts = '{2, 2, 0, 2};
      clear_fifos();
      for (int q = 0; q < Q; q++) fill(q, 10);
      do_reset("s3_rst");
      repeat (6) tick("s3");
      exp_q = '{0, 0, 1, 1, 3, 3};
      check_seq("s3_seq");

      // Backpressure: output frozen while not accepted, then resumes in order.
      wts = '{1, 2, 3, 4};
      clear_fifos();
      for (int q = 0; q < Q; q++) fill(q, 30);
      do_reset("s4_rst");
      repeat (3) tick("s4_pre");
      hold_data = m_data;
      hold_gid  = 2'(m_gid);
      ready_in  = 1'b0;
      repeat (5) tick("s4_stall");
      check("s4_hold_data", 32'(data_out), 32'(hold_data));
      check("s4_hold_gid",  32'(grant_id), 32'(hold_gid));
      check("s4_stall_pops", 32'(seen.size()), 32'd3);
      ready_in = 1'b1;
      repeat (7) tick("s4_post");
      build_pattern(10);
      check_seq("s4_seq");

      // Queue runs dry mid-turn: next queue served on the very next cycle.
      wts = '{4, 1, 1, 1};
      clear_fifos();
      fill(0, 2); fill(1, 3);
      do_reset("s5_rst");
      repeat (3) tick("s5");
      check("s5_no_bubble", 32'(seen.size()), 32'd3);
      repeat (3) tick("s5");
      exp_q = '{0, 0, 1, 1, 1};
      check_seq("s5_seq");

      // Reset mid-burst drops the in-flight word and restarts with fresh credit.
      wts = '{1, 2, 3, 4};
      clear_fifos();
      for (int q = 0; q < Q; q++) fill(q, 30);
      do_reset("s6_rst0");
      repeat (6) tick("s6_pre");
      do_reset("s6_rst");
      repeat (10) tick("s6_post");
      build_pattern(10);
      check_seq("s6_seq");

      // Random soak against the model: enable, backpressure, weights, arrivals, resets.
      for (int c = 0; c < 600; c++) begin
         rst      = ($urandom_range(0, 99) < 2);
         enb      = ($urandom_range(0, 99) < 90);
         ready_in = ($urandom_range(0, 99) < 70);
         if ($urandom_range(0, 9) == 0) begin
            wts[$urandom_range(0, Q-1)] = ($urandom_range(0, 3) == 0) ?
                                          int'($urandom_range(0, 63)) :
                                          int'($urandom_range(0, 4));
         end
         for (int q = 0; q < Q; q++) begin
            if ((cnt[q] < DEPTH - 2) && ($urandom_range(0, 3) == 0)) push(q, DB'($urandom));
         end
         tick("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
